vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Parametrised SRAM arbiter for video RAM; successor to the single-client memory manager.
//  Shares one async SRAM between the scanout reader (priority, burst-capped) and
//  NUM_CLIENTS generic client ports (round-robin).
//  Wait states and read/write turnaround are programmable.
//  Sits between VideoOutput/MCU-side clients and the external SRAM pins in the VGA top.
// PARAMETERS
//  ADDR_WIDTH      17  SRAM address width
//  DATA_WIDTH      8   SRAM data width
//  NUM_CLIENTS     2   client ports (>=1)
//  ACCESS_CYCLES   2   cycles per SRAM access, strobe active (>=1)
//  TURNAROUND      1   idle cycles after every write before next grant (>=0)
//  MAX_VIDEO_BURST 4   consecutive video grants before a pending client is forced in
// PORTS
//  clock               in   1                      system clock, all logic on rising edge
//  resetN              in   1                      async active-low reset
//  videoRequest        in   1                      scanout read request, level, held until ready
//  videoAddress        in   ADDR_WIDTH             scanout read address
//  videoData           out  DATA_WIDTH             scanout read data
//  videoDataReady      out  1                      1-cycle pulse, videoData valid
//  clientReadRequest   in   NUM_CLIENTS            per-client read request, level
//  clientWriteRequest  in   NUM_CLIENTS            per-client write request, level
//  clientAddress       in   NUM_CLIENTS*ADDR_WIDTH packed, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  clientWriteData     in   NUM_CLIENTS*DATA_WIDTH packed write data
//  clientReadData      out  DATA_WIDTH             shared read data, valid with ReadComplete
//  clientReadComplete  out  NUM_CLIENTS            1-cycle pulse per client
//  clientWriteComplete out  NUM_CLIENTS            1-cycle pulse per client
//  ramAddress          out  ADDR_WIDTH             SRAM address
//  ramData             io   DATA_WIDTH             SRAM data; Z unless writing
//  ramWriteEnable      out  1                      SRAM WE, active low
//  ramOutputEnable     out  1                      SRAM OE, active low
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; ramWriteEnable=1, ramOutputEnable=1, ramData=Z;
//   ramAddress=0; videoData/clientReadData=0; all ready/complete pulses=0;
//   RR pointer=0; burst counter=0. In-flight access aborted, no complete; requester reissues.
//  States: IDLE -> ACCESS (ACCESS_CYCLES) -> DONE (1) -> TURN (TURNAROUND, writes only) -> IDLE.
//   TURN is skipped when TURNAROUND=0.
//  IDLE: sample requests, pick a winner, register address/data/type, enter ACCESS next edge.
//  Arbitration order:
//   1. videoRequest wins, unless burstCount==MAX_VIDEO_BURST and any client is pending.
//   2. Otherwise round-robin from pointer; pointer moves to winner+1 mod NUM_CLIENTS.
//  burstCount: +1 per video grant (saturating); cleared on client grant or IDLE with no videoRequest.
//  Same client with Read and Write both high: treated as write; read stays pending.
//  ACCESS read: ramAddress stable, ramOutputEnable=0 all ACCESS cycles;
//   ramData sampled on the last ACCESS edge into the read register.
//  ACCESS write: ramData driven from first ACCESS cycle through DONE (hold);
//   ramWriteEnable=0 all ACCESS cycles, 1 in DONE; OE stays 1.
//  DONE: exactly one pulse of videoDataReady / clientReadComplete[i] / clientWriteComplete[i].
//   Read data held on output until next read completes.
//  Latency, grant in IDLE cycle t: complete pulse at t+1+ACCESS_CYCLES.
//   Next grant possible at t+2+ACCESS_CYCLES (+TURNAROUND after write).
//  Requesters must drop the request the cycle after complete.
//   A request still high in IDLE is a new access.
//  Request deasserted before grant: silently dropped.
//   Deasserted after grant: access completes, pulse still given.
//  ramAddress holds last value in IDLE/TURN; OE and WE never low simultaneously.
// STRUCTURE
//  Package vram_pkg:
//   - typedef enum {IDLE, ACCESS, DONE, TURN} vramState_t
//   - typedef enum {ACC_VIDEO, ACC_CLIENT_READ, ACC_CLIENT_WRITE} accessType_t
//  Sub-module round_robin_arbiter #(N): request vector + pointer -> one-hot grant.
//  Wait-state counter, burst counter and FSM live in vram_arbiter.
// TESTING (ACCESS_CYCLES=2, TURNAROUND=1, MAX_VIDEO_BURST=4, behavioural SRAM model)
//  1. Reset held, random inputs:
//     -> WE=1, OE=1, ramData=Z, all pulses 0; release: IDLE, no strobes.
//  2. Client0 read 17'h1ABCD, SRAM holds 8'h5A, request at IDLE cycle t:
//     -> OE=0 at t+1..t+2; clientReadComplete[0] at t+3; clientReadData=8'h5A.
//  3. Client1 write 8'h3C to 17'h00010:
//     -> WE=0 exactly 2 cycles, ramData=8'h3C for 3 cycles, then one TURN cycle
//        with OE=WE=1; SRAM[0x10]=8'h3C.
//  4. Clients 0 and 1 read continuously, no video:
//     -> grants alternate 0,1,0,1; each completes every 4 cycles.
//  5. videoRequest continuous, client0 read pending:
//     -> 4 video grants, then client0, then video resumes; videoDataReady count correct.
//  6. resetN low mid-write (first ACCESS cycle):
//     -> WE=1 and ramData=Z same cycle (async), no clientWriteComplete; after release, IDLE.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and width helper for the video RAM arbiter
package vram_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, TURN} vramState_t;

    typedef enum logic [1:0] {ACC_VIDEO, ACC_CLIENT_READ, ACC_CLIENT_WRITE} accessType_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int countWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - one-hot round-robin grant starting the search at pointer
module round_robin_arbiter
    import vram_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [N-1:0]               requests,
    input  logic [countWidth(N)-1:0]   pointer,
    output logic [N-1:0]               grant
);

    localparam int PW = countWidth(N);

    // Scan from the farthest slot back to the pointer so the nearest requester wins.
    always_comb begin
        int slot;
        grant = '0;
        slot  = 0;
        for (int offset = N - 1; offset >= 0; offset--) begin
            slot = (int'(pointer) + offset) % N;
            if (requests[PW'(slot)]) begin
                grant = N'(1) << slot;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares one async SRAM between the scanout reader and round-robin clients
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 17,
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_CLIENTS     = 2,
    parameter int ACCESS_CYCLES   = 2,
    parameter int TURNAROUND      = 1,
    parameter int MAX_VIDEO_BURST = 4
)(
    input  logic                              clock,
    input  logic                              resetN,
    input  logic                              videoRequest,
    input  logic [ADDR_WIDTH-1:0]             videoAddress,
    output logic [DATA_WIDTH-1:0]             videoData,
    output logic                              videoDataReady,
    input  logic [NUM_CLIENTS-1:0]            clientReadRequest,
    input  logic [NUM_CLIENTS-1:0]            clientWriteRequest,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] clientAddress,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] clientWriteData,
    output logic [DATA_WIDTH-1:0]             clientReadData,
    output logic [NUM_CLIENTS-1:0]            clientReadComplete,
    output logic [NUM_CLIENTS-1:0]            clientWriteComplete,
    output logic [ADDR_WIDTH-1:0]             ramAddress,
    inout  wire  [DATA_WIDTH-1:0]             ramData,
    output logic                              ramWriteEnable,
    output logic                              ramOutputEnable
);

    localparam int PW = countWidth(NUM_CLIENTS);
    localparam int WW = countWidth(ACCESS_CYCLES);
    localparam int TW = countWidth(TURNAROUND);
    localparam int BW = countWidth(MAX_VIDEO_BURST + 1);

    vramState_t             state;
    vramState_t             nextState;
    accessType_t            accessType;
    logic [PW-1:0]          rrPointer;
    logic [PW-1:0]          grantIndex;
    logic [PW-1:0]          activeClient;
    logic [NUM_CLIENTS-1:0] clientPendingVec;
    logic [NUM_CLIENTS-1:0] clientGrant;
    logic [NUM_CLIENTS-1:0] activeOneHot;
    logic                   clientPending;
    logic                   videoWins;
    logic                   lastAccessCycle;
    logic                   lastTurnCycle;
    logic                   isWrite;
    logic [WW-1:0]          waitCount;
    logic [TW-1:0]          turnCount;
    logic [BW-1:0]          burstCount;
    logic [DATA_WIDTH-1:0]  writeDataReg;

    assign clientPendingVec = clientReadRequest | clientWriteRequest;
    assign clientPending    = |clientPendingVec;
    // Video is pre-empted only once its burst is used up and a client is actually waiting.
    assign videoWins        = videoRequest &&
                              !((burstCount == BW'(MAX_VIDEO_BURST)) && clientPending);
    assign lastAccessCycle  = (waitCount == WW'(ACCESS_CYCLES - 1));
    assign lastTurnCycle    = (turnCount == TW'(TURNAROUND - 1));
    assign isWrite          = (accessType == ACC_CLIENT_WRITE);
    assign activeOneHot     = NUM_CLIENTS'(1) << activeClient;

    round_robin_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .requests (clientPendingVec),
        .pointer  (rrPointer),
        .grant    (clientGrant)
    );

    always_comb begin
        grantIndex = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (clientGrant[i]) begin
                grantIndex = PW'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (videoRequest || clientPending) nextState = ACCESS;
            ACCESS:  if (lastAccessCycle) nextState = DONE;
            DONE:    nextState = (isWrite && (TURNAROUND > 0)) ? TURN : IDLE;
            TURN:    if (lastTurnCycle) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            accessType     <= ACC_VIDEO;
            activeClient   <= '0;
            rrPointer      <= '0;
            burstCount     <= '0;
            waitCount      <= '0;
            turnCount      <= '0;
            writeDataReg   <= '0;
            ramAddress     <= '0;
            videoData      <= '0;
            clientReadData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    waitCount <= '0;
                    if (videoWins) begin
                        accessType <= ACC_VIDEO;
                        ramAddress <= videoAddress;
                        if (burstCount != BW'(MAX_VIDEO_BURST)) begin
                            burstCount <= burstCount + 1'b1;
                        end
                    end else if (clientPending) begin
                        // A simultaneous read from the same client stays pending behind the write.
                        accessType   <= clientWriteRequest[grantIndex] ? ACC_CLIENT_WRITE
                                                                       : ACC_CLIENT_READ;
                        activeClient <= grantIndex;
                        ramAddress   <= clientAddress[grantIndex*ADDR_WIDTH +: ADDR_WIDTH];
                        writeDataReg <= clientWriteData[grantIndex*DATA_WIDTH +: DATA_WIDTH];
                        rrPointer    <= PW'((int'(grantIndex) + 1) % NUM_CLIENTS);
                        burstCount   <= '0;
                    end else begin
                        burstCount <= '0;
                    end
                end
                ACCESS: begin
                    waitCount <= waitCount + 1'b1;
                    if (lastAccessCycle && !isWrite) begin
                        if (accessType == ACC_VIDEO) begin
                            videoData <= ramData;
                        end else begin
                            clientReadData <= ramData;
                        end
                    end
                end
                DONE: begin
                    turnCount <= '0;
                end
                TURN: begin
                    turnCount <= turnCount + 1'b1;
                end
                default: begin
                    turnCount <= '0;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset releases the bus immediately.
    assign ramWriteEnable      = !((state == ACCESS) && isWrite);
    assign ramOutputEnable     = !((state == ACCESS) && !isWrite);
    assign ramData             = (((state == ACCESS) || (state == DONE)) && isWrite)
                                 ? writeDataReg : 'z;
    assign videoDataReady      = (state == DONE) && (accessType == ACC_VIDEO);
    assign clientReadComplete  = ((state == DONE) && (accessType == ACC_CLIENT_READ))
                                 ? activeOneHot : '0;
    assign clientWriteComplete = ((state == DONE) && isWrite) ? activeOneHot : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a behavioural SRAM
module tb_vram_arbiter;

    localparam int AW  = 17;
    localparam int DW  = 8;
    localparam int NC  = 2;
    localparam int CAW = NC * AW;
    localparam int CDW = NC * DW;

    logic           clock = 1'b0;
    logic           resetN;
    logic           videoRequest;
    logic [AW-1:0]  videoAddress;
    logic [DW-1:0]  videoData;
    logic           videoDataReady;
    logic [NC-1:0]  clientReadRequest;
    logic [NC-1:0]  clientWriteRequest;
    logic [CAW-1:0] clientAddress;
    logic [CDW-1:0] clientWriteData;
    logic [DW-1:0]  clientReadData;
    logic [NC-1:0]  clientReadComplete;
    logic [NC-1:0]  clientWriteComplete;
    logic [AW-1:0]  ramAddress;
    wire  [DW-1:0]  ramData;
    logic           ramWriteEnable;
    logic           ramOutputEnable;

    logic [DW-1:0]  mem [0:(1<<AW)-1];
    logic [DW-1:0]  refMem [0:7];
    int             compared = 0;
    int             mismatched = 0;
    int             cycle = 0;

    vram_arbiter dut (
        .clock               (clock),
        .resetN              (resetN),
        .videoRequest        (videoRequest),
        .videoAddress        (videoAddress),
        .videoData           (videoData),
        .videoDataReady      (videoDataReady),
        .clientReadRequest   (clientReadRequest),
        .clientWriteRequest  (clientWriteRequest),
        .clientAddress       (clientAddress),
        .clientWriteData     (clientWriteData),
        .clientReadData      (clientReadData),
        .clientReadComplete  (clientReadComplete),
        .clientWriteComplete (clientWriteComplete),
        .ramAddress          (ramAddress),
        .ramData             (ramData),
        .ramWriteEnable      (ramWriteEnable),
        .ramOutputEnable     (ramOutputEnable)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Async SRAM: drives data while OE is low, stores while WE is low.
    assign ramData = (!ramOutputEnable && ramWriteEnable) ? mem[ramAddress] : 8'hzz;
    always @(posedge clock) if (!ramWriteEnable) mem[ramAddress] <= ramData;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    always @(negedge clock) begin
        if (resetN === 1'b1) begin
            check("oe_we_exclusive", {31'd0, (!ramOutputEnable && !ramWriteEnable)}, 32'd0);
        end
    end

    // who: -1 video, i client read, 10+i client write, -99 nothing within the budget.
    task automatic waitEvent(output int who, output int at);
        who = -99;
        at  = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (videoDataReady) who = -1;
            else if (|clientReadComplete) who = clientReadComplete[1] ? 1 : 0;
            else if (|clientWriteComplete) who = clientWriteComplete[1] ? 11 : 10;
            if (who != -99) begin
                at = cycle;
                break;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int who, at, prevAt, expWho, rrModel, burstModel, videoSeen, issue, c, wr, k;
        logic pend;
        logic [DW-1:0] d;
        logic [AW-1:0] a;

        videoRequest = 0; videoAddress = '0; clientReadRequest = '0; clientWriteRequest = '0;
        clientAddress = '0; clientWriteData = '0;
        resetN = 1'b1;
        #2 resetN = 1'b0;

        // 1: reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            videoRequest       = 1'($urandom);
            videoAddress       = AW'($urandom);
            clientReadRequest  = NC'($urandom);
            clientWriteRequest = NC'($urandom);
            clientAddress      = CAW'({$urandom(), $urandom()});
            clientWriteData    = CDW'($urandom);
            @(negedge clock);
            check("rst_we", ramWriteEnable, 1);
            check("rst_oe", ramOutputEnable, 1);
            check("rst_data_z", {31'd0, ramData === 8'hzz}, 1);
            check("rst_pulses", {videoDataReady, clientReadComplete, clientWriteComplete}, 0);
            check("rst_addr", ramAddress, 0);
            check("rst_rdata", {videoData, clientReadData}, 0);
            tick();
        end
        videoRequest = 0; clientReadRequest = '0; clientWriteRequest = '0;
        resetN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rel_strobes", {ramWriteEnable, ramOutputEnable}, 2'b11);
            check("rel_pulses", {videoDataReady, clientReadComplete, clientWriteComplete}, 0);
        end
        rrModel = 0;

        // 2: client0 read
        mem[17'h1ABCD] = 8'h5A;
        tick();
        clientAddress = CAW'(17'h1ABCD);
        clientReadRequest = 2'b01;
        @(negedge clock); check("t2_oe_idle", ramOutputEnable, 1);
        @(negedge clock); check("t2_oe_a1", ramOutputEnable, 0); check("t2_addr", ramAddress, 17'h1ABCD);
        @(negedge clock); check("t2_oe_a2", ramOutputEnable, 0);
        @(negedge clock);
        check("t2_complete", clientReadComplete, 2'b01);
        check("t2_rdata", clientReadData, 8'h5A);
        check("t2_oe_done", ramOutputEnable, 1);
        tick(); clientReadRequest = '0;
        rrModel = 1;

        // 3: client1 write
        tick();
        clientAddress = CAW'(17'h00010) << AW;
        clientWriteData = CDW'(8'h3C) << DW;
        clientWriteRequest = 2'b10;
        @(negedge clock); check("t3_we_idle", ramWriteEnable, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("t3_we_low", ramWriteEnable, 0);
            check("t3_oe_high", ramOutputEnable, 1);
            check("t3_wdata", ramData, 8'h3C);
        end
        @(negedge clock);
        check("t3_we_done", ramWriteEnable, 1);
        check("t3_wdata_hold", ramData, 8'h3C);
        check("t3_complete", clientWriteComplete, 2'b10);
        tick(); clientWriteRequest = '0;
        @(negedge clock);
        check("t3_turn_strobes", {ramWriteEnable, ramOutputEnable}, 2'b11);
        check("t3_turn_z", {31'd0, ramData === 8'hzz}, 1);
        check("t3_mem", mem[17'h10], 8'h3C);
        rrModel = 0;
        tick(); tick();

        // 4: both clients read continuously
        mem[17'h100] = 8'h11;
        mem[17'h200] = 8'h22;
        clientAddress = {17'h200, 17'h100};
        clientReadRequest = 2'b11;
        prevAt = -1;
        for (int g = 0; g < 4; g++) begin
            expWho = rrModel;
            rrModel = (rrModel + 1) % NC;
            waitEvent(who, at);
            check("t4_order", who, expWho);
            check("t4_rdata", clientReadData, (expWho == 0) ? 8'h11 : 8'h22);
            if (g > 0) check("t4_spacing", at - prevAt, 4);
            prevAt = at;
        end
        tick(); clientReadRequest = '0;
        tick();

        // 5: continuous video with client0 pending
        mem[17'h300] = 8'h77;
        videoAddress = 17'h300;
        videoRequest = 1;
        clientReadRequest = 2'b01;
        burstModel = 0; pend = 1; videoSeen = 0;
        for (int g = 0; g < 7; g++) begin
            if (burstModel == 4 && pend) begin
                expWho = 0;
                burstModel = 0;
            end else begin
                expWho = -1;
                if (burstModel < 4) burstModel++;
            end
            waitEvent(who, at);
            check("t5_grant", who, expWho);
            if (who == -1) begin
                videoSeen++;
                check("t5_vdata", videoData, 8'h77);
            end
            if (expWho == 0) begin
                check("t5_cdata", clientReadData, 8'h11);
                pend = 0;
                rrModel = 1;
                tick(); clientReadRequest = '0;
            end
        end
        tick(); videoRequest = 0;
        check("t5_video_count", videoSeen, 6);
        tick();

        // 6: reset during first ACCESS cycle of a write
        mem[17'h20] = 8'h00;
        clientAddress = CAW'(17'h20);
        clientWriteData = CDW'(8'h55);
        clientWriteRequest = 2'b01;
        @(posedge clock); #2;
        check("t6_we_active", ramWriteEnable, 0);
        resetN = 1'b0;
        #1;
        check("t6_we_async", ramWriteEnable, 1);
        check("t6_oe_async", ramOutputEnable, 1);
        check("t6_z_async", {31'd0, ramData === 8'hzz}, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_no_complete", clientWriteComplete, 0);
        end
        clientWriteRequest = '0;
        tick(); resetN = 1'b1;
        @(negedge clock);
        check("t6_post_strobes", {ramWriteEnable, ramOutputEnable}, 2'b11);
        check("t6_post_pulses", {videoDataReady, clientReadComplete, clientWriteComplete}, 0);
        check("t6_mem_untouched", mem[17'h20], 8'h00);
        rrModel = 0;

        // random single transactions against a reference memory
        for (int i = 0; i < 8; i++) begin
            a = AW'(17'h400 + i);
            d = DW'($urandom);
            mem[a] = d;
            refMem[i] = d;
        end
        for (int n = 0; n < 20; n++) begin
            c  = int'($urandom_range(0, 1));
            wr = int'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 7));
            d  = DW'($urandom);
            a  = AW'(17'h400 + k);
            tick();
            issue = cycle;
            clientAddress   = CAW'(a) << (c * AW);
            clientWriteData = CDW'(d) << (c * DW);
            if (wr == 1) begin
                clientWriteRequest = NC'(1) << c;
                clientReadRequest  = $urandom_range(0, 1) == 1 ? (NC'(1) << c) : '0;
            end else begin
                clientReadRequest = NC'(1) << c;
            end
            waitEvent(who, at);
            check("rnd_who", who, (wr == 1) ? 10 + c : c);
            check("rnd_latency", at - issue, 3);
            if (wr == 1) refMem[k] = d;
            else check("rnd_rdata", clientReadData, refMem[k]);
            tick();
            clientReadRequest = '0;
            clientWriteRequest = '0;
        end
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
